// File: rtl/if_cache_if.sv
// ---------------------------------------------------------------------------
// if_cache_if -- fetch-side and memory-side signal bundle for if_cache.
//
// The master is the fetch unit together with the refill memory controller.
// The slave is the cache.
//   rdy          global enable (hold everything when 0)
//   fetch_req    fetch request for pc_i this cycle
//   pc_i         word-aligned fetch address
//   flush        redirect: cancel forwarding of a pending miss
//   inv_all      invalidate the whole cache (fence.i)
//   mem_done_i   memory returns one word this cycle
//   mem_data_i   returned instruction word
//   mem_req_o    refill request (registered)
//   mem_addr_o   refill address (registered)
//   inst_valid_o pc_o / inst_o carry a delivered instruction
//   pc_o         address of the delivered instruction
//   inst_o       delivered instruction
//   if_stall     the fetch cannot complete this cycle
//   hit_cnt_o    saturating count of hit cycles
//   miss_cnt_o   saturating count of launched misses
// ---------------------------------------------------------------------------
interface if_cache_if;
    logic        rdy;
    logic        fetch_req;
    logic [31:0] pc_i;
    logic        flush;
    logic        inv_all;
    logic        mem_done_i;
    logic [31:0] mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        if_stall;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    modport master (
        output rdy, fetch_req, pc_i, flush, inv_all, mem_done_i, mem_data_i,
        input  mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o, if_stall,
               hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  rdy, fetch_req, pc_i, flush, inv_all, mem_done_i, mem_data_i,
        output mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o, if_stall,
               hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/if_cache.sv
// ---------------------------------------------------------------------------
// if_cache -- instruction fetch cache, one word per line, 1- or 2-way.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   if_cache_if.slave: fetch request in, instruction out, single
//         outstanding refill to the memory controller, perf counters.
//
// Parameters:
//   SETS  number of sets, power of two, 2..1024
//   WAYS  associativity, 1 or 2
//
// Hits are answered combinationally in the request cycle. A miss moves the
// FSM to ST_WAIT and raises a registered refill request; the returned word is
// written into the cache and, if the same pc is still being fetched and no
// flush / inv_all intervened, forwarded in the return cycle.
// ---------------------------------------------------------------------------
module if_cache #(
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 2
) (
    input logic       clk,
    input logic       rst,
    if_cache_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // control state
    state_t      state_q;
    logic [31:0] miss_addr_q;
    logic        kill_q;      // forwarding of the pending fill is cancelled
    logic        discard_q;   // pending fill must not be written at all
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // cache storage
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS];

    // address split
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign req_idx  = bus.pc_i[IDX_W+1:2];
    assign req_tag  = bus.pc_i[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // lookup
    logic        hit_any;
    logic        hit_way;
    logic [31:0] hit_data;

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = 1'b0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit_any  = 1'b1;
                hit_way  = w[0];
                hit_data = data_mem[w][req_idx];
            end
        end
    end

    // victim: first invalid way (way0 first), otherwise the LRU way
    logic victim;
    logic found_free;

    always_comb begin
        victim     = (WAYS == 2) ? lru_q[fill_idx] : 1'b0;
        found_free = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_free && !valid_q[w][fill_idx]) begin
                victim     = w[0];
                found_free = 1'b1;
            end
        end
    end

    // per-cycle events
    logic hit;
    logic done;
    logic fill_we;
    logic fwd;
    logic launch;

    assign hit     = bus.rdy & bus.fetch_req & hit_any;
    assign done    = (state_q == ST_WAIT) & bus.rdy & bus.mem_done_i & ~rst;
    // inv_all in the return cycle also discards; discard_q implies kill_q
    assign fill_we = done & ~discard_q & ~bus.inv_all;
    assign fwd     = done & bus.fetch_req & ~hit & (bus.pc_i == miss_addr_q)
                   & ~kill_q & ~bus.flush & ~bus.inv_all;
    assign launch  = (state_q == ST_IDLE) & bus.rdy & bus.fetch_req & ~hit;

    // outputs
    assign bus.inst_valid_o = hit | fwd;
    assign bus.pc_o         = (hit | fwd) ? bus.pc_i : '0;
    assign bus.inst_o       = hit ? hit_data : (fwd ? bus.mem_data_i : '0);
    assign bus.if_stall     = bus.rdy & bus.fetch_req & ~hit & ~fwd;
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.hit_cnt_o    = hit_cnt_q;
    assign bus.miss_cnt_o   = miss_cnt_q;

    // FSM, refill request and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            kill_q      <= 1'b0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else if (bus.rdy) begin
            if (hit && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q     <= ST_WAIT;
                        miss_addr_q <= bus.pc_i;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= bus.pc_i;
                        kill_q      <= bus.flush | bus.inv_all;
                        discard_q   <= bus.inv_all;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_done_i) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        discard_q <= 1'b0;
                    end else begin
                        if (bus.flush || bus.inv_all) begin
                            kill_q <= 1'b1;
                        end
                        if (bus.inv_all) begin
                            discard_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // valid and LRU bits; a fill in the same set as a hit wins the LRU bit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            lru_q <= '0;
        end else if (bus.rdy) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (bus.inv_all) begin
                    valid_q[w] <= '0;
                end else if (fill_we && w == {31'd0, victim}) begin
                    valid_q[w][fill_idx] <= 1'b1;
                end
            end
            if (hit) begin
                lru_q[req_idx] <= ~hit_way;
            end
            if (fill_we) begin
                lru_q[fill_idx] <= ~victim;
            end
        end
    end

    // tag and data arrays, no reset needed
    always_ff @(posedge clk) begin
        if (fill_we) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (w == {31'd0, victim}) begin
                    tag_mem[w][fill_idx]  <= fill_tag;
                    data_mem[w][fill_idx] <= bus.mem_data_i;
                end
            end
        end
    end

endmodule
